// File: rtl/grid_io_bank_programmer_if.sv
// Configuration channel and grid-tile drive lines for grid_io_bank_programmer.
// With PROG_PARITY_CHECK_EN defined the channel carries cfg_parity as well.
interface grid_io_bank_programmer_if #(
  parameter int BL_WIDTH = 8,
  parameter int WL_WIDTH = 8
);
  localparam int ADDR_W = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ADDR_W-1:0]     cfg_wl_addr;
  logic [0:BL_WIDTH-1]   cfg_bl_data;
  logic                  cfg_last;
  logic                  cfg_clear;
`ifdef PROG_PARITY_CHECK_EN
  logic                  cfg_parity;
`endif
  logic [0:BL_WIDTH-1]   bl;
  logic [0:WL_WIDTH-1]   wl;
  logic                  prog_done;
  logic                  prog_err;

`ifdef PROG_PARITY_CHECK_EN
  modport master (
    output cfg_valid, cfg_wl_addr, cfg_bl_data, cfg_last, cfg_clear, cfg_parity,
    input  cfg_ready, bl, wl, prog_done, prog_err
  );
  modport slave (
    input  cfg_valid, cfg_wl_addr, cfg_bl_data, cfg_last, cfg_clear, cfg_parity,
    output cfg_ready, bl, wl, prog_done, prog_err
  );
`else
  modport master (
    output cfg_valid, cfg_wl_addr, cfg_bl_data, cfg_last, cfg_clear,
    input  cfg_ready, bl, wl, prog_done, prog_err
  );
  modport slave (
    input  cfg_valid, cfg_wl_addr, cfg_bl_data, cfg_last, cfg_clear,
    output cfg_ready, bl, wl, prog_done, prog_err
  );
`endif
endinterface

// File: rtl/grid_io_bank_programmer.sv
// Memory-bank programming sequencer: each config word becomes setup -> one-hot WL pulse -> hold.
// Optional feature macro PROG_PARITY_CHECK_EN: checks cfg_parity (even, over data and addr) at accept.
module grid_io_bank_programmer #(
  parameter int BL_WIDTH     = 8,
  parameter int WL_WIDTH     = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input logic                      prog_clk,
  input logic                      prog_reset_n,
  grid_io_bank_programmer_if.slave cfg
);
  localparam int ADDR_W   = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int MAX_SP   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_C    = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CNT_W    = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   WL_LIMIT   = (ADDR_W + 1)'(WL_WIDTH);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [0:BL_WIDTH-1] data_q, data_d;
  logic                last_q, last_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic [0:WL_WIDTH-1] wl_q, wl_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept_s;
  logic                word_ok_s;

`ifdef PROG_PARITY_CHECK_EN
  function automatic logic even_parity(input logic [BL_WIDTH-1:0] data,
                                       input logic [ADDR_W-1:0]   addr);
    return ^{data, addr};
  endfunction
`endif

  // Sequencer next state, counter reload and the next values of all registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    last_d   = last_q;
    err_d    = err_q;
    bl_d     = '0;
    wl_d     = '0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    accept_s = cfg.cfg_valid & ready_q;
`ifdef PROG_PARITY_CHECK_EN
    word_ok_s = ({1'b0, cfg.cfg_wl_addr} < WL_LIMIT) &&
                (cfg.cfg_parity == even_parity(cfg.cfg_bl_data, cfg.cfg_wl_addr));
`else
    word_ok_s = ({1'b0, cfg.cfg_wl_addr} < WL_LIMIT);
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d = cfg.cfg_wl_addr;
          data_d = cfg.cfg_bl_data;
          last_d = cfg.cfg_last;
          if (word_ok_s) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            // Dropped word: flag it, and still honour end-of-bitstream
            err_d   = 1'b1;
            state_d = cfg.cfg_last ? ST_DONE : ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = last_q ? ST_DONE : ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (cfg.cfg_clear) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs follow the state being entered so they change exactly on the edge
    case (state_d)
      ST_IDLE:  ready_d = 1'b1;
      ST_SETUP: bl_d    = data_d;
      ST_PULSE: begin
        bl_d = data_d;
        for (int i = 0; i < WL_WIDTH; i++) begin
          wl_d[i] = (addr_d == ADDR_W'(i));
        end
      end
      ST_HOLD:  bl_d    = data_d;
      ST_DONE:  done_d  = 1'b1;
      default:  ready_d = 1'b0;
    endcase
  end

  // State, latched word and registered outputs
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      bl_q    <= '0;
      wl_q    <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.bl        = bl_q;
  assign cfg.wl        = wl_q;
  assign cfg.prog_done = done_q;
  assign cfg.prog_err  = err_q;
endmodule
